// File: rtl/mux_8to1.sv
// Registered 8-to-1 single-bit multiplexer: y takes d[s] one clock after sampling.
// The only state is the y flop; reset clears it asynchronously.
module mux_8to1 #(
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  d,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    logic y_d;
    logic y_q;

    // Every one of the eight codes is decoded explicitly.
    // The default arm is reached only for a non-binary select.
    function automatic logic select_bit(input logic [N_IN-1:0] din,
                                        input logic [SEL_W-1:0] sel);
        logic bit_v;
        case (sel)
            3'd0:    bit_v = din[0];
            3'd1:    bit_v = din[1];
            3'd2:    bit_v = din[2];
            3'd3:    bit_v = din[3];
            3'd4:    bit_v = din[4];
            3'd5:    bit_v = din[5];
            3'd6:    bit_v = din[6];
            3'd7:    bit_v = din[7];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    // Next-state select of the addressed data bit
    always_comb begin
        y_d = 1'b0;
        y_d = select_bit(d, s);
    end

    // Output flop: loads every cycle, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_mux_8to1.sv
// Scoreboard bench for mux_8to1: expected bits are queued when stimulus is driven
// and popped and compared once the registered output should carry them.
module tb_mux_8to1;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic [2:0] s;
    logic       y;

    int   n_vec;
    int   n_err;
    logic sb_q[$];

    mux_8to1 #(.N_IN(8), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .s     (s),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: y=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_sel(input logic [7:0] dv, input logic [2:0] sv);
        logic [7:0] shifted;
        shifted = dv >> sv;
        return shifted[0];
    endfunction

    // Pop the oldest expectation and compare it with y now.
    task automatic pop_check(input string tag);
        logic exp;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, y=%b", tag, y);
        end else begin
            exp = sb_q.pop_front();
            check_bit(tag, y, exp);
        end
    endtask

    // Called just after a rising edge: drive, push, wait one edge, check.
    task automatic step(input string tag, input logic [7:0] dv, input logic [2:0] sv);
        d = dv;
        s = sv;
        sb_q.push_back(model_sel(dv, sv));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        d     = 8'hFF;
        s     = 3'b000;

        #1;
        sb_q.push_back(1'b0);
        pop_check("reset_t0");
        repeat (3) begin
            @(posedge clk);
            #1;
            sb_q.push_back(1'b0);
            pop_check("reset_held");
        end

        #4;
        rst_n = 1'b1;
        sb_q.push_back(1'b1);
        @(posedge clk);
        #1;
        pop_check("reset_release");

        for (int i = 0; i < 8; i++) begin
            step("sweep_aa", 8'b1010_1010, 3'(i));
        end

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                step("onehot", 8'(1 << i), 3'(j));
            end
        end

        step("latency_pre", 8'h00, 3'b011);
        d = 8'h08;
        #3;
        sb_q.push_back(1'b0);
        pop_check("latency_hold");
        sb_q.push_back(1'b1);
        @(posedge clk);
        #1;
        pop_check("latency_edge");

        step("async_pre", 8'hFF, 3'b101);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(1'b0);
        pop_check("async_reset");
        #1;
        rst_n = 1'b1;
        sb_q.push_back(1'b1);
        @(posedge clk);
        #1;
        pop_check("async_release");

        step("simul_pre", 8'h01, 3'b000);
        step("simul_chg", 8'h80, 3'b111);
        step("simul_old", 8'h01, 3'b111);

        for (int k = 0; k < 24; k++) begin
            step("random", 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
